// File: rtl/writeback_queue_if.sv
// writeback_queue_if: producer handshake, register-file write port and bypass lookup
// bundled for writeback_queue_m; master = pipeline side, slave = the queue.
`default_nettype none

interface writeback_queue_if #(
  parameter int DEPTH = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_reg_write;
  logic                      in_mem_to_reg;
  logic [4:0]                in_rd;
  logic signed [31:0]        in_alu_result;
  logic signed [31:0]        in_mem_data;
  logic                      wb_stall;
  logic                      RegWrite;
  logic [4:0]                writeRegister;
  logic signed [31:0]        writeData;
  logic [$clog2(DEPTH):0]    count;
  logic [4:0]                fwd_reg;
  logic                      fwd_hit;
  logic signed [31:0]        fwd_data;

  modport slave (
    input  in_valid, in_reg_write, in_mem_to_reg, in_rd, in_alu_result, in_mem_data,
    input  wb_stall, fwd_reg,
    output in_ready, RegWrite, writeRegister, writeData, count, fwd_hit, fwd_data
  );

  modport master (
    output in_valid, in_reg_write, in_mem_to_reg, in_rd, in_alu_result, in_mem_data,
    output wb_stall, fwd_reg,
    input  in_ready, RegWrite, writeRegister, writeData, count, fwd_hit, fwd_data
  );
endinterface

`default_nettype wire

// File: rtl/writeback_queue_m.sv
//------------------------------------------------------------------------------
// writeback_queue_m: DEPTH-entry FIFO between pipeline writeback and register file,
// one write per cycle, optional bypass lookup enabled by macro WB_FORWARD_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module writeback_queue_m #(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  writeback_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]         rd_mem_q   [DEPTH];
  logic signed [31:0] data_mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic [CW-1:0]      count_d;
  logic               regwrite_q;
  logic [4:0]         wreg_q;
  logic signed [31:0] wdata_q;

  logic               in_hs;
  logic               do_enq;
  logic               do_deq;
  logic signed [31:0] in_data;

  assign bus.in_ready = (count_q != CW'(DEPTH));
  assign in_hs        = bus.in_valid && bus.in_ready;
  // Non-register-writing and XZR results complete the handshake but are dropped.
  assign do_enq       = in_hs && bus.in_reg_write && (bus.in_rd != 5'd31);
  assign do_deq       = (count_q != '0) && !bus.wb_stall;
  assign in_data      = bus.in_mem_to_reg ? bus.in_mem_data : bus.in_alu_result;

  always_comb begin
    count_d = count_q;
    if (do_enq && !do_deq) begin
      count_d = count_q + CW'(1);
    end else if (!do_enq && do_deq) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) begin
      rd_mem_q[wr_ptr_q]   <= bus.in_rd;
      data_mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
    end else begin
      count_q <= count_d;
      if (do_enq) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_deq) begin
        rd_ptr_q   <= rd_ptr_q + AW'(1);
        regwrite_q <= 1'b1;
        wreg_q     <= rd_mem_q[rd_ptr_q];
        wdata_q    <= data_mem_q[rd_ptr_q];
      end else begin
        regwrite_q <= 1'b0;
      end
    end
  end

  assign bus.RegWrite      = regwrite_q;
  assign bus.writeRegister = wreg_q;
  assign bus.writeData     = wdata_q;
  assign bus.count         = count_q;

`ifdef WB_FORWARD_EN
  logic [AW-1:0]      fwd_idx;
  logic               fwd_hit_d;
  logic signed [31:0] fwd_data_d;

  // Scan oldest to newest so the last match (queue tail) wins.
  always_comb begin
    fwd_hit_d  = 1'b0;
    fwd_data_d = '0;
    fwd_idx    = '0;
    if (bus.fwd_reg != 5'd31) begin
      if (regwrite_q && (wreg_q == bus.fwd_reg)) begin
        fwd_hit_d  = 1'b1;
        fwd_data_d = wdata_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        fwd_idx = rd_ptr_q + AW'(i);
        if ((CW'(i) < count_q) && (rd_mem_q[fwd_idx] == bus.fwd_reg)) begin
          fwd_hit_d  = 1'b1;
          fwd_data_d = data_mem_q[fwd_idx];
        end
      end
    end
  end

  assign bus.fwd_hit  = fwd_hit_d;
  assign bus.fwd_data = fwd_data_d;
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^bus.fwd_reg;
  assign bus.fwd_hit  = 1'b0;
  assign bus.fwd_data = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_writeback_queue_m.sv
// tb_writeback_queue_m: directed and random stimulus against a queue-based reference model.
`default_nettype none

module tb_writeback_queue_m;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  writeback_queue_if #(.DEPTH(DEPTH)) wb_if ();

  writeback_queue_m #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (wb_if.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference: pending writes as {rd, data}, plus the visible output register.
  logic [36:0] mq [$];
  logic        m_rw;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rw = 1'b0;
    m_wr = '0;
    m_wd = '0;
  endtask

  task automatic model_edge();
    logic        acc;
    logic [31:0] d;
    logic [36:0] e;
    acc = wb_if.in_valid && (mq.size() != DEPTH);
    d   = wb_if.in_mem_to_reg ? wb_if.in_mem_data : wb_if.in_alu_result;
    if (mq.size() > 0 && !wb_if.wb_stall) begin
      e    = mq.pop_front();
      m_rw = 1'b1;
      m_wr = e[36:32];
      m_wd = e[31:0];
    end else begin
      m_rw = 1'b0;
    end
    if (acc && wb_if.in_reg_write && wb_if.in_rd != 5'd31)
      mq.push_back({wb_if.in_rd, d});
  endtask

  task automatic exp_fwd(output logic hit, output logic [31:0] data);
    hit  = 1'b0;
    data = '0;
`ifdef WB_FORWARD_EN
    if (wb_if.fwd_reg != 5'd31) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (!hit && mq[i][36:32] == wb_if.fwd_reg) begin
          hit  = 1'b1;
          data = mq[i][31:0];
        end
      end
      if (!hit && m_rw && m_wr == wb_if.fwd_reg) begin
        hit  = 1'b1;
        data = m_wd;
      end
    end
`endif
  endtask

  task automatic check_all(input string ph);
    logic        eh;
    logic [31:0] ed;
    exp_fwd(eh, ed);
    check({ph, ".RegWrite"},      32'(wb_if.RegWrite),      32'(m_rw));
    check({ph, ".writeRegister"}, 32'(wb_if.writeRegister), 32'(m_wr));
    check({ph, ".writeData"},     wb_if.writeData,          m_wd);
    check({ph, ".count"},         32'(wb_if.count),         32'(mq.size()));
    check({ph, ".in_ready"},      32'(wb_if.in_ready),      32'(mq.size() != DEPTH));
    check({ph, ".fwd_hit"},       32'(wb_if.fwd_hit),       32'(eh));
    check({ph, ".fwd_data"},      wb_if.fwd_data,           ed);
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] mem);
    wb_if.in_valid      = v;
    wb_if.in_reg_write  = rw;
    wb_if.in_mem_to_reg = m2r;
    wb_if.in_rd         = rd;
    wb_if.in_alu_result = alu;
    wb_if.in_mem_data   = mem;
  endtask

  task automatic step(input string ph);
    model_edge();
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  task automatic check_zero(input string ph);
    check({ph, ".RegWrite"},      32'(wb_if.RegWrite),      32'd0);
    check({ph, ".writeRegister"}, 32'(wb_if.writeRegister), 32'd0);
    check({ph, ".writeData"},     wb_if.writeData,          32'd0);
    check({ph, ".count"},         32'(wb_if.count),         32'd0);
    check({ph, ".in_ready"},      32'(wb_if.in_ready),      32'd1);
    check({ph, ".fwd_hit"},       32'(wb_if.fwd_hit),       32'd0);
    check({ph, ".fwd_data"},      wb_if.fwd_data,           32'd0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    wb_if.wb_stall = 1'b0;
    wb_if.fwd_reg  = 5'd0;
    model_reset();
    #1;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Single write, one-cycle latency after acceptance.
    wb_if.fwd_reg = 5'd5;
    drive(1'b1, 1'b1, 1'b0, 5'd5, 32'h11, 32'hDEAD);
    step("w5_acc");
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    step("w5_out");
    check("w5_data17", wb_if.writeData, 32'd17);
    step("w5_idle");

    // Load-mux write, then two dropped writes.
    wb_if.fwd_reg = 5'd9;
    drive(1'b1, 1'b1, 1'b1, 5'd9, 32'h55, -32'sd4);
    step("w9");
    drive(1'b1, 1'b1, 1'b0, 5'd31, 32'h77, 32'h0);
    step("xzr");
    drive(1'b1, 1'b0, 1'b0, 5'd3, 32'h66, 32'h0);
    step("norw");
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    step("drop_idle");

    // Fill under stall, attempt a fifth, then drain in order.
    wb_if.wb_stall = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      drive(1'b1, 1'b1, 1'b0, 5'(r), 32'(r * 16), 32'd0);
      step("fill");
    end
    drive(1'b1, 1'b1, 1'b0, 5'd6, 32'h99, 32'd0);
    step("full_hold");
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    wb_if.wb_stall = 1'b0;
    for (int r = 0; r < 5; r++) step("drain");

    // Two pending writes to the same register: newest wins.
    wb_if.wb_stall = 1'b1;
    wb_if.fwd_reg  = 5'd7;
    drive(1'b1, 1'b1, 1'b0, 5'd7, 32'd100, 32'd0);
    step("f100");
    drive(1'b1, 1'b1, 1'b0, 5'd7, 32'd200, 32'd0);
    step("f200");
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    #1 check_all("f7");
    wb_if.fwd_reg = 5'd31;
    #1 check_all("f31");
    wb_if.wb_stall = 1'b0;
    wb_if.fwd_reg  = 5'd7;
    for (int r = 0; r < 3; r++) step("fdrain");

    // Randomized traffic: continuous valid first, then sparse.
    for (int n = 0; n < 400; n++) begin
      drive((n < 200) ? 1'b1 : 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) != 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7)),
            $urandom, $urandom);
      wb_if.wb_stall = ($urandom_range(0, 9) < 4);
      wb_if.fwd_reg  = ($urandom_range(0, 8) == 8) ? 5'd31 : 5'($urandom_range(0, 7));
      step("rand");
    end

    // Reset in the middle of a drain.
    wb_if.wb_stall = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    for (int r = 0; r < 6; r++) step("pre_flush");
    for (int r = 10; r < 14; r++) begin
      drive(1'b1, 1'b1, 1'b0, 5'(r), 32'(r), 32'd0);
      step("rfill");
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    wb_if.wb_stall = 1'b0;
    wb_if.fwd_reg  = 5'd11;
    step("rdrain");
    check("rdrain.count3", 32'(wb_if.count), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_zero("async_rst");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int r = 0; r < 5; r++) step("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/writeback_queue_m.md
WRITEBACK_QUEUE_M -- requirements
Module: writeback_queue_m

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  producer offers a writeback result.
REQ-005 in_ready  output  1  queue can accept; handshake completes when in_valid && in_ready at a rising edge.
REQ-006 in_reg_write  input  1  result targets a register.
REQ-007 in_mem_to_reg  input  1  1 selects in_mem_data, 0 selects in_alu_result.
REQ-008 in_rd  input  5  destination register index.
REQ-009 in_alu_result  input  32 signed  ALU result.
REQ-010 in_mem_data  input  32 signed  data-memory load result.
REQ-011 wb_stall  input  1  register file cannot take a write this cycle.
REQ-012 RegWrite  output  1  register-file write enable, registered.
REQ-013 writeRegister  output  5  register-file write index, registered.
REQ-014 writeData  output  32 signed  register-file write data, registered.
REQ-015 count  output  $clog2(DEPTH)+1  current queue occupancy.
REQ-016 fwd_reg  input  5  bypass lookup index.
REQ-017 fwd_hit  output  1  a pending write to fwd_reg exists.
REQ-018 fwd_data  output  32 signed  newest pending value for fwd_reg.

Function
REQ-019 in_ready SHALL be 1 iff count != DEPTH; no enqueue when full, even with a simultaneous dequeue.
REQ-020 The data mux (in_mem_to_reg) SHALL be resolved at enqueue; the queue stores {rd[4:0], data[31:0]}.
REQ-021 A handshake with in_reg_write=0 or in_rd=31 (XZR) SHALL complete but SHALL NOT enqueue; count unchanged.
REQ-022 Each edge with count>0 and wb_stall=0 SHALL pop the head into writeRegister/writeData and set RegWrite=1 for exactly that cycle.
REQ-023 Each edge with count=0 or wb_stall=1 SHALL set RegWrite=0; writeRegister/writeData hold their last values; queue unchanged.
REQ-024 Latency: a write accepted at edge N into an empty queue, with wb_stall=0, SHALL show RegWrite=1 after edge N+1.
REQ-025 Writes SHALL leave the queue in acceptance order; one write per cycle maximum.
REQ-026 Enqueue and dequeue on the same edge SHALL leave count unchanged; read/write pointers SHALL wrap modulo DEPTH.
REQ-027 RegWrite SHALL never assert with writeRegister=31.

Reset
REQ-028 rst_n=0 SHALL, without waiting for clk, clear pointers and count and set RegWrite=0, writeRegister=0, writeData=0, fwd_hit=0, fwd_data=0.
REQ-029 Entries pending at reset SHALL be discarded; a handshake on the edge coinciding with reset assertion SHALL be lost.
REQ-030 After rst_n rises, in_ready SHALL be 1 and the first write SHALL follow REQ-024 timing.

Configuration
REQ-031 Macro WB_FORWARD_EN defined: fwd_hit/fwd_data SHALL be combinational over all queue entries plus the output register while RegWrite=1; fwd_data SHALL be the newest match (queue tail first, output register last); fwd_reg=31 gives hit=0, data=0.
REQ-032 Macro WB_FORWARD_EN undefined: the ports SHALL remain, with fwd_hit and fwd_data tied to 0 and no lookup logic.

Verification
REQ-033 Reset, then one write rd=5, alu=32'h00000011, mem_to_reg=0 -> edge after acceptance gives RegWrite=1, writeRegister=5, writeData=17 for one cycle.
REQ-034 rd=9, mem=-4, mem_to_reg=1; then rd=31 and reg_write=0 writes -> only rd=9/-4 emerges; count never exceeds 1.
REQ-035 wb_stall=1, push 4 writes rd=1..4 -> count=4, in_ready=0, RegWrite=0; release stall -> rd 1,2,3,4 on four consecutive cycles.
REQ-036 Full queue, continuous in_valid, stall toggled -> no accepted write lost or reordered; pointers wrap across at least 3 laps.
REQ-037 WB_FORWARD_EN, stall=1, push rd=7 with 100 then rd=7 with 200 -> fwd_reg=7 gives hit=1, data=200; fwd_reg=31 gives hit=0.
REQ-038 Assert rst_n=0 mid-drain with count=3 -> outputs zero immediately without a clock edge; after release no stale write appears.
